led_string_rx: RTL and testbench

Single-wire LED string receiver: decodes the pulse-width NRZ stream that the string drivers put on one led_sdi line back into 24-bit pixel words.
Sits on clk_20 as a loopback and self-test monitor, one instance per monitored string.
Reports each decoded pixel, the pixel count per frame, the frame latch and timing violations, so firmware and benches can check driver output against the FIFO contents.

---
 rtl/led_string_rx.sv | 154 +++++++++++++++
 tb/tb_led_string_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_string_rx.sv
// Single-wire LED string receiver: decodes the pulse-width NRZ stream on sdi
// into 24-bit pixel words, with per-frame pixel counts and timing errors.
module led_string_rx #(
  parameter int HIGH_THRESH    = 12,
  parameter int MIN_HIGH       = 4,
  parameter int MAX_HIGH       = 24,
  parameter int LATCH_LOW      = 1000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int COUNT_WIDTH    = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sdi,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic [COUNT_WIDTH-1:0]    pixel_count,
  output logic                      frame_done,
  output logic [COUNT_WIDTH-1:0]    frame_pixels,
  output logic                      bit_err
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(LATCH_LOW + 1);
  localparam int IW = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0] H_SAT = HW'(MAX_HIGH + 1);
  localparam logic [HW-1:0] H_THR = HW'(HIGH_THRESH);
  localparam logic [LW-1:0] L_END = LW'(LATCH_LOW - 1);
  localparam logic [LW-1:0] L_MAX = LW'(LATCH_LOW);
  localparam logic [IW-1:0] I_LAST = IW'(BITS_PER_PIXEL - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t state, state_nxt;

  logic                      s1, sdi_s, sdi_q;
  logic                      rise, fall;
  logic [HW-1:0]             hcnt;
  logic [LW-1:0]             lcnt;
  logic [IW-1:0]             bidx;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic                      bit_end, bad, good, bitv;
  logic                      word_done, latch;

  // Sync flops reset high so a line already high at release is no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      sdi_s <= 1'b1;
      sdi_q <= 1'b1;
    end else begin
      s1    <= sdi;
      sdi_s <= s1;
      sdi_q <= sdi_s;
    end
  end

  assign rise = sdi_s & ~sdi_q;
  assign fall = ~sdi_s & sdi_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: if (fall) state_nxt = LOW;
      LOW: begin
        if (rise)       state_nxt = HIGH;
        else if (latch) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_end   = (state == HIGH) && fall;
    bad       = bit_end && ((hcnt < H_MIN) || (hcnt > H_MAX));
    good      = bit_end && !bad;
    bitv      = (hcnt >= H_THR);
    word_done = good && (bidx == I_LAST);
    latch     = (state == LOW) && !sdi_s && (lcnt == L_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt         <= '0;
      lcnt         <= '0;
      bidx         <= '0;
      shreg        <= '0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      pixel_count  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      bit_err      <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_err     <= 1'b0;

      if (rise)
        hcnt <= HW'(1);
      else if (state == HIGH && sdi_s && hcnt != H_SAT)
        hcnt <= hcnt + 1'b1;

      if (fall)
        lcnt <= LW'(1);
      else if (state == LOW && !sdi_s && lcnt != L_MAX)
        lcnt <= lcnt + 1'b1;

      if (frame_done) pixel_count <= '0;

      if (bad) begin
        bit_err <= 1'b1;
        shreg   <= '0;
        bidx    <= '0;
      end else if (good) begin
        shreg <= {shreg[BITS_PER_PIXEL-2:0], bitv};
        if (word_done) begin
          pixel_data  <= {shreg[BITS_PER_PIXEL-2:0], bitv};
          pixel_valid <= 1'b1;
          bidx        <= '0;
          if (pixel_count != '1) pixel_count <= pixel_count + 1'b1;
        end else begin
          bidx <= bidx + 1'b1;
        end
      end

      // Latch gap: drop any partial pixel, report a non-empty frame
      if (latch) begin
        if (bidx != '0) begin
          bit_err <= 1'b1;
          bidx    <= '0;
          shreg   <= '0;
        end
        if (pixel_count != '0) begin
          frame_done   <= 1'b1;
          frame_pixels <= pixel_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_string_rx.sv
// Directed bench for led_string_rx: pixel decode, frame latch,
// glitch/partial errors, threshold edges and mid-pixel reset.
module tb_led_string_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sdi;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [8:0]  pixel_count;
  logic        frame_done;
  logic [8:0]  frame_pixels;
  logic        bit_err;

  led_string_rx dut (
    .clk          (clk),
    .reset        (reset),
    .sdi          (sdi),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_count  (pixel_count),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .bit_err      (bit_err)
  );

  always #25 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int nerr = 0;
  int nframe = 0;
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid) begin
        nvalid++;
        got_q.push_back(pixel_data);
      end
      if (bit_err)    nerr++;
      if (frame_done) nframe++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    nvalid = 0;
    nerr   = 0;
    nframe = 0;
    got_q.delete();
  endtask

  task automatic pulse(input int h, input int l);
    sdi = 1'b1;
    repeat (h) @(negedge clk);
    sdi = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input int last_low);
    for (int i = 23; i >= 0; i--) begin
      if (i == 0) pulse(w[i] ? 16 : 8, last_low);
      else        pulse(w[i] ? 16 : 8, w[i] ? 9 : 17);
    end
  endtask

  task automatic fast_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--)
      pulse(w[i] ? 12 : 4, 1);
  endtask

  initial begin
    logic [23:0] w;
    sdi   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_data",   pixel_data,   0);
    chk("rst_valid",  pixel_valid,  0);
    chk("rst_count",  pixel_count,  0);
    chk("rst_fdone",  frame_done,   0);
    chk("rst_fpix",   frame_pixels, 0);
    chk("rst_err",    bit_err,      0);

    // single pixel
    clr();
    send_word(24'hA5C33C, 17);
    repeat (5) @(negedge clk);
    chk("one_nvalid", nvalid, 1);
    chk("one_data",   pixel_data, 24'hA5C33C);
    chk("one_count",  pixel_count, 1);
    chk("one_err",    nerr, 0);
    repeat (1000) @(negedge clk);
    chk("one_frame",  nframe, 1);
    chk("one_fpix",   frame_pixels, 1);
    chk("one_clr",    pixel_count, 0);

    // 236 random pixels, short legal pulses
    clr();
    exp_q.delete();
    for (int p = 0; p < 236; p++) begin
      w = 24'($urandom);
      exp_q.push_back(w);
      fast_word(w);
    end
    repeat (1010) @(negedge clk);
    chk("str_nvalid", nvalid, 236);
    for (int p = 0; p < 236 && p < got_q.size(); p++)
      chk($sformatf("str_px%0d", p), got_q[p], exp_q[p]);
    chk("str_frame",  nframe, 1);
    chk("str_fpix",   frame_pixels, 236);
    chk("str_count",  pixel_count, 0);
    chk("str_err",    nerr, 0);

    // glitch after 10 bits
    clr();
    for (int i = 0; i < 10; i++) pulse(i % 2 ? 16 : 8, i % 2 ? 9 : 17);
    pulse(2, 10);
    chk("gl_err",     nerr, 1);
    chk("gl_novalid", nvalid, 0);
    send_word(24'h123456, 1010);
    chk("gl_nvalid",  nvalid, 1);
    chk("gl_data",    pixel_data, 24'h123456);
    chk("gl_err2",    nerr, 1);
    chk("gl_frame",   nframe, 1);
    chk("gl_fpix",    frame_pixels, 1);

    // partial pixel at latch
    clr();
    for (int i = 0; i < 11; i++) pulse(i % 3 ? 8 : 16, i % 3 ? 17 : 9);
    pulse(16, 1010);
    chk("pp_err",     nerr, 1);
    chk("pp_valid",   nvalid, 0);
    chk("pp_frame",   nframe, 0);
    chk("pp_count",   pixel_count, 0);

    // threshold boundaries
    clr();
    pulse(11, 17);
    pulse(12, 13);
    pulse(24, 5);
    for (int i = 0; i < 20; i++) pulse(8, 17);
    pulse(8, 999);
    pulse(25, 999);
    chk("th_nvalid",  nvalid, 1);
    chk("th_data",    pixel_data, 24'h600000);
    chk("th_err",     nerr, 1);
    chk("th_nolatch", nframe, 0);
    send_word(24'h00FF00, 1000);
    pulse(8, 20);
    chk("th_frame",   nframe, 1);
    chk("th_fpix",    frame_pixels, 2);
    chk("th_data2",   pixel_data, 24'h00FF00);
    repeat (1010) @(negedge clk);
    chk("th_err2",    nerr, 2);
    chk("th_frame2",  nframe, 1);
    chk("th_count",   pixel_count, 0);

    // reset mid-pixel with line high
    for (int i = 0; i < 5; i++) pulse(16, 9);
    sdi = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clr();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rm_data",    pixel_data, 0);
    chk("rm_count",   pixel_count, 0);
    chk("rm_fpix",    frame_pixels, 0);
    chk("rm_valid",   nvalid, 0);
    chk("rm_errn",    nerr, 0);
    sdi = 1'b0;
    repeat (10) @(negedge clk);
    send_word(24'hC0FFEE, 1010);
    chk("rm_nvalid",  nvalid, 1);
    chk("rm_data2",   pixel_data, 24'hC0FFEE);
    chk("rm_err",     nerr, 0);
    chk("rm_frame",   nframe, 1);
    chk("rm_fpix2",   frame_pixels, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
